// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one start/ready multiplier among N requesters.
// Define MULT_ARB_TIMEOUT_EN to build the WAIT-state watchdog (resp_err on expiry).
module mult_arbiter #(
  parameter int SZ      = 32,
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 _rst,
  input  logic [N-1:0]         req_valid,
  input  logic [N*SZ-1:0]      req_a,
  input  logic [N*SZ-1:0]      req_b,
  output logic [N-1:0]         req_ready,
  output logic [N-1:0]         resp_valid,
  input  logic [N-1:0]         resp_ready,
  output logic [2*SZ-1:0]      resp_res,
  output logic                 resp_err,
  output logic [SZ-1:0]        mult_a,
  output logic [SZ-1:0]        mult_b,
  output logic                 mult_start,
  input  logic                 mult_ready,
  input  logic [2*SZ-1:0]      mult_res,
  output logic                 busy,
  output logic [$clog2(N)-1:0] grant_id
);

  localparam int GW = $clog2(N);

  if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_param_check
    $error("mult_arbiter: N must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [SZ-1:0]   a_q, a_d;
  logic [SZ-1:0]   b_q, b_d;
  logic [2*SZ-1:0] res_q, res_d;
  logic            found;
  logic [GW-1:0]   win;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] g);
    return (int'(g) == N - 1) ? '0 : g + 1'b1;
  endfunction

  // First valid requester at or after the round-robin pointer
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_valid[(int'(ptr_q) + k) % N]) begin
        found = 1'b1;
        win   = GW'((int'(ptr_q) + k) % N);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    req_ready  = '0;
    resp_valid = '0;
    mult_start = 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          req_ready[win] = 1'b1;
          a_d            = req_a[int'(win)*SZ +: SZ];
          b_d            = req_b[int'(win)*SZ +: SZ];
          grant_d        = win;
          ptr_d          = next_idx(win);
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        mult_start = 1'b1;
        state_d    = WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d      = '0;
`endif
      end
      WAIT: begin
        // A ready on the expiry cycle still counts as a normal completion
        if (mult_ready) begin
          res_d   = mult_res;
          state_d = RESP;
`ifdef MULT_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      RESP: begin
        resp_valid[grant_q] = 1'b1;
        if (resp_ready[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (_rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign resp_err = err_q;
`else
  assign resp_err = 1'b0;
`endif

  assign mult_a   = a_q;
  assign mult_b   = b_q;
  assign resp_res = res_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model (round-robin pick, plain product, expected latency).
`timescale 1ns/1ps
module tb_mult_arbiter;
  localparam int SZ      = 32;
  localparam int N       = 4;
  localparam int TIMEOUT = 16;
  localparam int GW      = $clog2(N);

  logic              clk = 1'b0;
  logic              _rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N*SZ-1:0]   req_a = '0;
  logic [N*SZ-1:0]   req_b = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      resp_valid;
  logic [N-1:0]      resp_ready = '0;
  logic [2*SZ-1:0]   resp_res;
  logic              resp_err;
  logic [SZ-1:0]     mult_a, mult_b;
  logic              mult_start;
  logic              mult_ready;
  logic [2*SZ-1:0]   mult_res;
  logic              busy;
  logic [GW-1:0]     grant_id;

  mult_arbiter #(.SZ(SZ), .N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), ._rst(_rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_res(resp_res), .resp_err(resp_err),
    .mult_a(mult_a), .mult_b(mult_b), .mult_start(mult_start),
    .mult_ready(mult_ready), .mult_res(mult_res),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: ready drops on start, rises lat_cfg+1 edges later (never if 0)
  int lat_cfg = 1;
  int mcnt;
  always @(posedge clk) begin
    if (_rst) begin
      mult_ready <= 1'b0;
      mult_res   <= '0;
      mcnt       <= 0;
    end else if (mult_start) begin
      mult_ready <= 1'b0;
      mult_res   <= 64'(mult_a) * 64'(mult_b);
      mcnt       <= lat_cfg;
    end else if (mcnt == 1) begin
      mult_ready <= 1'b1;
      mcnt       <= 0;
    end else if (mcnt > 1) begin
      mcnt <= mcnt - 1;
    end
  end

  // Reference model state
  logic [SZ-1:0] a_m [N];
  logic [SZ-1:0] b_m [N];
  logic [N-1:0]  vmask = '0;
  int            ptr_m = 0;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (vmask[(ptr_m + k) % N]) return (ptr_m + k) % N;
    return -1;
  endfunction

  function automatic logic [SZ-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return SZ'($urandom);
    endcase
  endfunction

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_a[i*SZ +: SZ] = a_m[i];
      req_b[i*SZ +: SZ] = b_m[i];
    end
    req_valid = vmask;
  endtask

  task automatic do_reset();
    vmask      = '0;
    resp_ready = '0;
    apply();
    _rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    _rst  = 1'b0;
    ptr_m = 0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req_ready"},  req_ready,  0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_res"},   resp_res,   0);
    check({tag, "_resp_err"},   resp_err,   0);
    check({tag, "_mult_a"},     mult_a,     0);
    check({tag, "_mult_b"},     mult_b,     0);
    check({tag, "_mult_start"}, mult_start, 0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_grant_id"},   grant_id,   0);
  endtask

  // One full transaction from the current IDLE cycle; lat==0 means the multiplier never answers
  task automatic serve(input int lat, input int hold, output int gid);
    int g, cyc, exp_lat;
    logic [63:0] exp_res;
    logic exp_err;
    apply();
    lat_cfg = lat;
    #1;
    g = pick();
    check("accept_req_ready", req_ready, oh(g));
    check("accept_start_low", mult_start, 0);
    if (lat == 0) begin
      exp_res = '0; exp_err = 1'b1; exp_lat = TIMEOUT + 2;
    end else begin
      exp_res = 64'(a_m[g]) * 64'(b_m[g]); exp_err = 1'b0; exp_lat = lat + 3;
    end
    @(posedge clk); #1;
    gid = int'(grant_id);
    check("issue_start", mult_start, 1);
    check("issue_grant_id", grant_id, g);
    check("issue_mult_a", mult_a, a_m[g]);
    check("issue_mult_b", mult_b, b_m[g]);
    check("issue_req_ready", req_ready, 0);
    check("issue_busy", busy, 1);
    ptr_m    = (g + 1) % N;
    vmask[g] = 1'b0;
    apply();
    cyc = 1;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (resp_valid == '0 && cyc < 200);
    check("latency", cyc, exp_lat);
    check("resp_valid", resp_valid, oh(g));
    check("resp_res", resp_res, exp_res);
    check("resp_err", resp_err, exp_err);
    check("resp_start_low", mult_start, 0);
    resp_ready = ~oh(g);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_resp_valid", resp_valid, oh(g));
      check("hold_resp_res", resp_res, exp_res);
      check("hold_req_ready", req_ready, 0);
    end
    resp_ready = oh(g);
    @(posedge clk); #1;
    resp_ready = '0;
    check("done_resp_valid", resp_valid, 0);
    check("done_busy", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    int gid, seen;
    for (int i = 0; i < N; i++) begin a_m[i] = '0; b_m[i] = '0; end

    do_reset();
    check_idle("reset");

    // Single requester 3*5
    a_m[0] = 3; b_m[0] = 5; vmask = 4'b0001;
    serve(4, 0, gid);
    check("single_gid", gid, 0);
    check("single_res15", resp_res, 15);

    // Simultaneous requesters 1 and 2 from reset; pointer then sits at 3
    do_reset();
    a_m[1] = 7; b_m[1] = 9; a_m[2] = 11; b_m[2] = 13; vmask = 4'b0110;
    serve(2, 0, gid);
    check("sim_first", gid, 1);
    serve(1, 0, gid);
    check("sim_second", gid, 2);
    vmask = 4'b1111;
    for (int i = 0; i < N; i++) begin a_m[i] = rnd_op(); b_m[i] = rnd_op(); end
    serve(1, 0, gid);
    check("sim_ptr3", gid, 3);

    // Full contention, 8 operations
    do_reset();
    for (int i = 0; i < N; i++) begin a_m[i] = rnd_op(); b_m[i] = rnd_op(); end
    vmask = '1;
    for (int i = 0; i < 8; i++) begin
      serve($urandom_range(1, 5), 0, gid);
      check("contention_order", gid, i % N);
      for (int j = 0; j < N; j++)
        if (!vmask[j]) begin vmask[j] = 1'b1; a_m[j] = rnd_op(); b_m[j] = rnd_op(); end
    end

    // Response backpressure with max operands while others wait
    do_reset();
    a_m[1] = 2; b_m[1] = 2; vmask = 4'b0010;
    serve(1, 0, gid);
    a_m[2] = '1; b_m[2] = '1; a_m[3] = 6; b_m[3] = 7; a_m[0] = 4; b_m[0] = 4;
    vmask = 4'b1101;
    serve(3, 10, gid);
    check("bp_gid", gid, 2);
    check("bp_res", resp_res, 64'hFFFFFFFE00000001);
    serve(2, 0, gid);
    check("bp_next_gid", gid, 3);

    // Reset during WAIT abandons the operation and rewinds the pointer
    do_reset();
    a_m[1] = 5; b_m[1] = 5; vmask = 4'b0010;
    apply(); lat_cfg = 6; #1;
    check("rst_accept", req_ready, 4'b0010);
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_wait_busy", busy, 1);
    vmask = '0; apply(); _rst = 1'b1;
    @(posedge clk); #1;
    _rst = 1'b0;
    check_idle("midrst");
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (resp_valid != '0 || busy) seen++;
    end
    check("midrst_no_resp", seen, 0);
    ptr_m = 0;
    a_m[0] = 8; b_m[0] = 3; a_m[3] = 1; b_m[3] = 1; vmask = 4'b1001;
    serve(2, 0, gid);
    check("midrst_grant0", gid, 0);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++)
        if (!vmask[i] && $urandom_range(0, 1) == 1) begin
          vmask[i] = 1'b1; a_m[i] = rnd_op(); b_m[i] = rnd_op();
        end
      if (vmask == '0) begin vmask[0] = 1'b1; a_m[0] = rnd_op(); b_m[0] = rnd_op(); end
      serve($urandom_range(1, 6), $urandom_range(0, 3), gid);
    end

`ifdef MULT_ARB_TIMEOUT_EN
    // Watchdog: multiplier never answers
    do_reset();
    a_m[0] = 9; b_m[0] = 9; vmask = 4'b0001;
    serve(0, 1, gid);
    check("wd_err_gid", gid, 0);
    a_m[1] = 3; b_m[1] = 4; vmask = 4'b0010;
    serve(2, 0, gid);
    check("wd_recover_err", resp_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin controller that shares one `mult` multiplier instance between N requesters. It accepts one operand pair at a time from the winning requester and sequences the multiplier through its start/ready handshake. It returns the 2*SZ-bit product to that requester over a valid/ready response channel. It sits between the bus-side slave logic (Avalon-MM / AXI4 wrappers) and the shared multiplier datapath.

## Interface
- `SZ`, 32, operand width; product width is 2*SZ
- `N`, 4, number of requesters (2..8)
- `TIMEOUT`, 64, watchdog limit in cycles; used only with the macro
- `clk`  in  1  single clock, rising edge
- `_rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  N  requester i has an operand pair
- `req_a`  in  N*SZ  operand a of requester i, at bits [i*SZ +: SZ]
- `req_b`  in  N*SZ  operand b of requester i, packed the same way
- `req_ready`  out  N  one-hot acceptance pulse
- `resp_valid`  out  N  one-hot; result is pending for requester i
- `resp_ready`  in  N  requester i takes its result
- `resp_res`  out  2*SZ  product, shared by all requesters
- `resp_err`  out  1  watchdog expiry flag, qualified by `resp_valid`
- `mult_a`, `mult_b`  out  SZ  operands to the multiplier
- `mult_start`  out  1  one-cycle start pulse
- `mult_ready`  in  1  multiplier result valid; low while computing
- `mult_res`  in  2*SZ  multiplier product
- `busy`  out  1  high in any state other than IDLE
- `grant_id`  out  $clog2(N)  index of the current or last winner

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid` is high, pick winner g by round-robin starting at pointer `ptr`.
  - Drive `req_ready[g]=1` combinationally in the same cycle.
  - Latch `req_a`/`req_b` slice g into `mult_a`/`mult_b`; latch `grant_id=g`.
  - Set `ptr=(g+1) mod N`; go to ISSUE.
- **ISSUE**
  - `mult_start=1` for exactly this cycle; go to WAIT.
  - `mult_a`/`mult_b` stay stable from ISSUE until the state leaves WAIT.
- **WAIT**
  - `mult_ready` is ignored until WAIT is entered.
  - On the first WAIT cycle with `mult_ready=1`: latch `mult_res` into `resp_res`, clear `resp_err`, go to RESP.
- **RESP**
  - `resp_valid[g]=1`; `resp_res` is stable.
  - When `resp_ready[g]=1`, the handshake completes; go to IDLE next cycle.
  - `resp_ready` bits of non-winners are ignored.
- At most one operation is in flight; `req_ready` is all-zero outside IDLE.
- Requesters that are not granted keep `req_valid` asserted; no request is dropped.
- Arithmetic is unsigned full-width: 0xFFFFFFFF*0xFFFFFFFF gives 0xFFFFFFFE00000001 (SZ=32).
- Reset values: state IDLE, `ptr=0`, `grant_id=0`, and all of `req_ready`, `resp_valid`, `resp_res`, `resp_err`, `mult_a`, `mult_b`, `mult_start`, `busy` are 0.
- Reset mid-operation abandons the transaction: no response is issued and `ptr` returns to 0. `mult` shares `_rst`, so the multiplier resets too.
- If `req_valid[g]` drops while the FSM is in ISSUE/WAIT/RESP, the operation still completes and the response is still offered.

## Timing
- Cycle T: IDLE accept. T+1: ISSUE, `mult_start=1`. T+2 onward: WAIT.
- If `mult_ready` is seen at WAIT cycle T+1+k (k≥1), `resp_valid` rises at T+2+k.
- Minimum accept-to-`resp_valid` latency is 3 cycles.
- Earliest next accept is the cycle after the response handshake. Back-to-back throughput is therefore one operation per (k+3) cycles when `resp_ready` is held high.

## Configuration
- Macro: `MULT_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter clears on entry to WAIT and increments every WAIT cycle.
  - If it reaches `TIMEOUT` before `mult_ready` is seen, go to RESP with `resp_res=0` and `resp_err=1`.
  - `mult_ready` arriving on the same cycle as expiry wins, and `resp_err` stays 0.
- **Undefined:** no counter is built; `resp_err` is tied to 0 and WAIT waits indefinitely.

## Test plan
- **Single requester:** requester 0 sends a=3, b=5; the model multiplier is ready 4 cycles after start.
  - `req_ready[0]` pulses at T.
  - `mult_start` is high only at T+1.
  - `resp_valid[0]` rises and `resp_res=15`.
- **Simultaneous requests:** requesters 1 and 2 assert in the same cycle from reset.
  - Requester 1 is served first, then 2.
  - `grant_id` reads 1 then 2; `ptr` ends at 3.
- **Full contention:** all 4 requesters held valid for 8 operations.
  - Grant order is 0,1,2,3,0,1,2,3; no requester is starved.
- **Response backpressure:** `resp_ready` is held low 10 cycles in RESP with a=b=0xFFFFFFFF.
  - `resp_res=0xFFFFFFFE00000001` is stable throughout and `req_ready` stays 0.
  - The next accept occurs the cycle after `resp_ready` is raised.
- **Reset mid-WAIT:** assert `_rst` for 1 cycle during WAIT.
  - All outputs read 0 next cycle; no `resp_valid` follows.
  - The next request is granted starting from requester 0.
- **Watchdog (`MULT_ARB_TIMEOUT_EN`, TIMEOUT=16):** `mult_ready` is never asserted.
  - `resp_valid` rises 16 WAIT cycles after entry, with `resp_err=1` and `resp_res=0`.
